// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared codes, state encoding and floor helpers for the lift call scheduler
package lift_pkg;

    localparam logic [1:0] MOTOR_STOP = 2'b00;
    localparam logic [1:0] MOTOR_UP   = 2'b01;
    localparam logic [1:0] MOTOR_DOWN = 2'b10;

    localparam logic [1:0] FLOOR_1 = 2'd1;
    localparam logic [1:0] FLOOR_2 = 2'd2;
    localparam logic [1:0] FLOOR_3 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MOVE_UP   = 3'd1,
        ST_MOVE_DOWN = 3'd2,
        ST_DWELL     = 3'd3,
        ST_OVERLOAD  = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // One-hot request/switch bit for a floor number; out-of-range floors map to no bit.
    function automatic logic [2:0] floor_mask(input logic [1:0] floor);
        case (floor)
            FLOOR_1: floor_mask = 3'b001;
            FLOOR_2: floor_mask = 3'b010;
            FLOOR_3: floor_mask = 3'b100;
            default: floor_mask = 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] nearest_above(input logic [2:0] pend, input logic [1:0] floor);
        nearest_above = 2'd0;
        if (floor == FLOOR_1) begin
            if (pend[1])      nearest_above = FLOOR_2;
            else if (pend[2]) nearest_above = FLOOR_3;
        end else if (floor == FLOOR_2 && pend[2]) begin
            nearest_above = FLOOR_3;
        end
    endfunction

    function automatic logic [1:0] nearest_below(input logic [2:0] pend, input logic [1:0] floor);
        nearest_below = 2'd0;
        if (floor == FLOOR_3) begin
            if (pend[1])      nearest_below = FLOOR_2;
            else if (pend[0]) nearest_below = FLOOR_1;
        end else if (floor == FLOOR_2 && pend[0]) begin
            nearest_below = FLOOR_1;
        end
    endfunction

endpackage

// File: rtl/lift_dwell_timer.sv
// rtl/lift_dwell_timer.sv - load/restart down-counter, done once CYCLES enabled cycles have elapsed since load
module lift_dwell_timer
#(
    parameter int CYCLES = 8000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_done
);

    localparam int             W        = $clog2(CYCLES);
    localparam logic [W-1:0]   LOAD_VAL = W'(CYCLES - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_en && r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/lift_call_scheduler.sv
// rtl/lift_call_scheduler.sv - SCAN call scheduler and motor sequencer for a 3-floor freight lift
// Optional per-leg travel watchdog: define LIFT_TRAVEL_WATCHDOG_EN.
module lift_call_scheduler
    import lift_pkg::*;
#(
    parameter int DWELL_CYCLES   = 8000000,
    parameter int TIMEOUT_CYCLES = 40000000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [2:0] i_call,
    input  logic [2:0] i_fc,
    input  logic       i_sp,
    output logic [1:0] o_motor,
    output logic [2:0] o_pending,
    output logic [1:0] o_cur_floor,
    output logic [1:0] o_target_floor,
    output logic       o_door_open,
    output logic       o_overload_flag,
    output logic       o_fault
);

    state_t     r_state;
    dir_t       r_dir;
    logic [1:0] r_motor;
    logic [2:0] r_pending;
    logic [1:0] r_cur_floor;
    logic [1:0] r_target_floor;
    logic       r_door_open;
    logic       r_overload_flag;
    logic       r_fault;

    logic       w_fc_conflict;
    logic       w_moving;
    logic [2:0] w_cur_mask;
    logic       w_call_cur;
    logic [2:0] w_call_set;
    logic [2:0] w_pend_next;
    logic [1:0] w_up_target;
    logic [1:0] w_dn_target;
    logic       w_go_up;
    logic       w_go_dn;
    logic [1:0] w_floor_up;
    logic [1:0] w_floor_dn;
    logic       w_arrive_up;
    logic       w_arrive_dn;
    logic       w_stop_up;
    logic       w_stop_dn;
    logic       w_dwell_load;
    logic       w_dwell_done;
    logic       w_wd_done;
    logic       w_wd_trip;

    assign w_fc_conflict = (i_fc[0] & i_fc[1]) | (i_fc[0] & i_fc[2]) | (i_fc[1] & i_fc[2]);
    assign w_moving      = (r_state == ST_MOVE_UP) || (r_state == ST_MOVE_DOWN);
    assign w_cur_mask    = floor_mask(r_cur_floor);
    assign w_call_cur    = |(i_call & w_cur_mask);

    // A button at the floor being served extends the dwell instead of raising a request.
    assign w_call_set  = i_call & ~((r_state == ST_DWELL) ? w_cur_mask : 3'b000);
    assign w_pend_next = r_pending | w_call_set;

    assign w_up_target = nearest_above(r_pending, r_cur_floor);
    assign w_dn_target = nearest_below(r_pending, r_cur_floor);
    assign w_go_up     = (w_up_target != 2'd0) && ((r_dir == DIR_UP) || (w_dn_target == 2'd0));
    assign w_go_dn     = (w_dn_target != 2'd0) && !w_go_up;

    assign w_floor_up  = r_cur_floor + 2'd1;
    assign w_floor_dn  = r_cur_floor - 2'd1;
    assign w_arrive_up = |(i_fc & floor_mask(w_floor_up));
    assign w_arrive_dn = |(i_fc & floor_mask(w_floor_dn));
    assign w_stop_up   = (|(r_pending & floor_mask(w_floor_up))) || (w_floor_up == FLOOR_3);
    assign w_stop_dn   = (|(r_pending & floor_mask(w_floor_dn))) || (w_floor_dn == FLOOR_1);

    // Held loaded outside DWELL so every entry starts from a full count.
    assign w_dwell_load = (r_state != ST_DWELL) || w_call_cur;

    lift_dwell_timer #(.CYCLES(DWELL_CYCLES)) u_dwell_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_dwell_load),
        .i_en    (r_state == ST_DWELL),
        .o_done  (w_dwell_done)
    );

`ifdef LIFT_TRAVEL_WATCHDOG_EN
    lift_dwell_timer #(.CYCLES(TIMEOUT_CYCLES)) u_leg_watchdog (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (!w_moving),
        .i_en    (w_moving),
        .o_done  (w_wd_done)
    );
`else
    assign w_wd_done = (TIMEOUT_CYCLES < 1);
`endif

    assign w_wd_trip = w_moving && w_wd_done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            r_dir           <= DIR_UP;
            r_motor         <= MOTOR_STOP;
            r_pending       <= 3'b000;
            r_cur_floor     <= FLOOR_1;
            r_target_floor  <= 2'd0;
            r_door_open     <= 1'b0;
            r_overload_flag <= 1'b0;
            r_fault         <= 1'b0;
        end else if (r_state != ST_FAULT && (w_fc_conflict || w_wd_trip)) begin
            r_state <= ST_FAULT;
            r_motor <= MOTOR_STOP;
            r_fault <= 1'b1;
        end else begin
            if (r_state != ST_FAULT) begin
                r_pending <= w_pend_next;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_sp) begin
                        r_state         <= ST_OVERLOAD;
                        r_door_open     <= 1'b1;
                        r_overload_flag <= 1'b1;
                    end else if (|(r_pending & w_cur_mask)) begin
                        r_state     <= ST_DWELL;
                        r_door_open <= 1'b1;
                        r_pending   <= w_pend_next & ~w_cur_mask;
                    end else if (w_go_up) begin
                        r_state        <= ST_MOVE_UP;
                        r_dir          <= DIR_UP;
                        r_motor        <= MOTOR_UP;
                        r_target_floor <= w_up_target;
                    end else if (w_go_dn) begin
                        r_state        <= ST_MOVE_DOWN;
                        r_dir          <= DIR_DOWN;
                        r_motor        <= MOTOR_DOWN;
                        r_target_floor <= w_dn_target;
                    end
                end
                ST_MOVE_UP: begin
                    if (w_arrive_up) begin
                        r_cur_floor <= w_floor_up;
                        if (w_stop_up) begin
                            r_state        <= ST_DWELL;
                            r_motor        <= MOTOR_STOP;
                            r_door_open    <= 1'b1;
                            r_target_floor <= 2'd0;
                            r_pending      <= w_pend_next & ~floor_mask(w_floor_up);
                        end else begin
                            r_target_floor <= nearest_above(r_pending, w_floor_up);
                        end
                    end
                end
                ST_MOVE_DOWN: begin
                    if (w_arrive_dn) begin
                        r_cur_floor <= w_floor_dn;
                        if (w_stop_dn) begin
                            r_state        <= ST_DWELL;
                            r_motor        <= MOTOR_STOP;
                            r_door_open    <= 1'b1;
                            r_target_floor <= 2'd0;
                            r_pending      <= w_pend_next & ~floor_mask(w_floor_dn);
                        end else begin
                            r_target_floor <= nearest_below(r_pending, w_floor_dn);
                        end
                    end
                end
                ST_DWELL: begin
                    if (i_sp) begin
                        r_state         <= ST_OVERLOAD;
                        r_overload_flag <= 1'b1;
                    end else if (!w_call_cur && w_dwell_done) begin
                        r_state     <= ST_IDLE;
                        r_door_open <= 1'b0;
                    end
                end
                ST_OVERLOAD: begin
                    if (!i_sp) begin
                        r_state         <= ST_DWELL;
                        r_overload_flag <= 1'b0;
                        r_pending       <= w_pend_next & ~w_cur_mask;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_motor         = r_motor;
    assign o_pending       = r_pending;
    assign o_cur_floor     = r_cur_floor;
    assign o_target_floor  = r_target_floor;
    assign o_door_open     = r_door_open;
    assign o_overload_flag = r_overload_flag;
    assign o_fault         = r_fault;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// tb/tb_lift_call_scheduler.sv - randomized and directed bench against a floor-level lift model
module tb_lift_call_scheduler;

    localparam int DWELL   = 4;
    localparam int TIMEOUT = 20;
    localparam int SEG     = 6;

    localparam int M_IDLE  = 0;
    localparam int M_UP    = 1;
    localparam int M_DOWN  = 2;
    localparam int M_DWELL = 3;
    localparam int M_OVL   = 4;
    localparam int M_FAULT = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] call;
    logic [2:0] fc;
    logic       sp;
    logic [1:0] o_motor;
    logic [2:0] o_pending;
    logic [1:0] o_cur_floor;
    logic [1:0] o_target_floor;
    logic       o_door_open;
    logic       o_overload_flag;
    logic       o_fault;

    always #5 clk = ~clk;

    lift_call_scheduler #(.DWELL_CYCLES(DWELL), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_call          (call),
        .i_fc            (fc),
        .i_sp            (sp),
        .o_motor         (o_motor),
        .o_pending       (o_pending),
        .o_cur_floor     (o_cur_floor),
        .o_target_floor  (o_target_floor),
        .o_door_open     (o_door_open),
        .o_overload_flag (o_overload_flag),
        .o_fault         (o_fault)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Floor-level model: floors are integers 1..3, requests a bit per floor.
    int         m_mode, m_cur, m_target, m_motor, m_cnt, m_leg;
    bit         m_up, m_door, m_ovl, m_fault;
    logic [3:1] m_pend, m_next;

    int  pos;
    bit  stuck, force_on;
    logic [2:0] fc_force;

    function automatic int nearest(input logic [3:1] p, input int from, input bit up);
        int best = 0;
        if (up) begin
            for (int f = 3; f > from; f--) if (p[f]) best = f;
        end else begin
            for (int f = 1; f < from; f++) if (p[f]) best = f;
        end
        return best;
    endfunction

    task automatic model_enter_dwell();
        m_mode   = M_DWELL;
        m_motor  = 0;
        m_door   = 1;
        m_target = 0;
        m_cnt    = 0;
        m_next[m_cur] = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic [2:0] c, input logic [2:0] f, input logic s);
        int  hits, above, below, nxt;
        bit  timed_out;
        if (r) begin
            m_mode = M_IDLE; m_cur = 1; m_target = 0; m_motor = 0; m_cnt = 0; m_leg = 0;
            m_up = 1; m_door = 0; m_ovl = 0; m_fault = 0; m_pend = '0;
            return;
        end
        if (m_mode == M_FAULT) return;
        hits = int'(f[0]) + int'(f[1]) + int'(f[2]);
        timed_out = 0;
        if (m_mode == M_UP || m_mode == M_DOWN) begin
            m_leg++;
`ifdef LIFT_TRAVEL_WATCHDOG_EN
            timed_out = (m_leg >= TIMEOUT);
`endif
        end
        if (hits > 1 || timed_out) begin
            m_mode = M_FAULT; m_motor = 0; m_fault = 1;
            return;
        end
        m_next = m_pend;
        for (int fl = 1; fl <= 3; fl++)
            if (c[fl-1] && !(m_mode == M_DWELL && fl == m_cur)) m_next[fl] = 1'b1;
        above = nearest(m_pend, m_cur, 1'b1);
        below = nearest(m_pend, m_cur, 1'b0);
        case (m_mode)
            M_IDLE: begin
                if (s) begin
                    m_mode = M_OVL; m_door = 1; m_ovl = 1;
                end else if (m_pend[m_cur]) begin
                    model_enter_dwell();
                end else if (above != 0 && (m_up || below == 0)) begin
                    m_mode = M_UP; m_up = 1; m_motor = 1; m_target = above; m_leg = 0;
                end else if (below != 0) begin
                    m_mode = M_DOWN; m_up = 0; m_motor = 2; m_target = below; m_leg = 0;
                end
            end
            M_UP, M_DOWN: begin
                nxt = (m_mode == M_UP) ? m_cur + 1 : m_cur - 1;
                if (nxt >= 1 && nxt <= 3 && f[nxt-1]) begin
                    m_cur = nxt;
                    if (m_pend[nxt] || nxt == 3 || nxt == 1) model_enter_dwell();
                    else m_target = nearest(m_pend, nxt, m_mode == M_UP);
                end
            end
            M_DWELL: begin
                if (s) begin
                    m_mode = M_OVL; m_ovl = 1;
                end else if (c[m_cur-1]) begin
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == DWELL) begin
                        m_mode = M_IDLE; m_door = 0;
                    end
                end
            end
            M_OVL: begin
                if (!s) begin
                    m_ovl = 0;
                    model_enter_dwell();
                end
            end
            default: begin
            end
        endcase
        m_pend = m_next;
    endtask

    function automatic logic [2:0] car_fc();
        logic [2:0] v = '0;
        if (force_on) return fc_force;
        if (stuck) return 3'b000;
        for (int fl = 1; fl <= 3; fl++) v[fl-1] = (pos == (fl - 1) * SEG);
        return v;
    endfunction

    task automatic tick();
        logic [11:0] exp_v;
        @(posedge clk);
        model_step(rst, call, fc, sp);
        @(negedge clk);
        exp_v = {m_motor[1:0], m_pend, m_cur[1:0], m_target[1:0], m_door, m_ovl, m_fault};
        check_eq("outputs", {o_motor, o_pending, o_cur_floor, o_target_floor,
                             o_door_open, o_overload_flag, o_fault}, exp_v);
        if (m_motor == 1 && pos < 2 * SEG) pos++;
        else if (m_motor == 2 && pos > 0) pos--;
        fc = car_fc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pos = 0;
        fc = car_fc();
    endtask

    initial begin
        int n;
        int sp_hold;
        rst = 1'b1; call = '0; sp = 1'b0;
        pos = 0; stuck = 0; force_on = 0; fc_force = '0;
        fc = car_fc();
        tick();
        tick();
        check_eq("rst_motor", o_motor, 0);
        check_eq("rst_pending", o_pending, 0);
        check_eq("rst_cur_floor", o_cur_floor, 1);
        check_eq("rst_target", o_target_floor, 0);
        check_eq("rst_flags", {o_door_open, o_overload_flag, o_fault}, 0);

        rst = 1'b0; call = 3'b100;
        tick();
        check_eq("s1_pending_latch", o_pending, 3'b100);
        call = '0;
        tick();
        check_eq("s1_motor_up", o_motor, 1);
        check_eq("s1_target", o_target_floor, 3);
        for (int i = 0; i < 40 && !o_door_open; i++) tick();
        check_eq("s1_door", o_door_open, 1);
        check_eq("s1_cur_floor", o_cur_floor, 3);
        check_eq("s1_pending_clr", o_pending, 0);
        n = 0;
        while (o_door_open && n < 20) begin n++; tick(); end
        check_eq("s1_dwell_len", n, DWELL);

        call = 3'b001; tick(); call = '0;
        for (int i = 0; i < 60 && !(o_door_open && o_cur_floor == 1); i++) tick();
        check_eq("s2_at_floor1", o_cur_floor, 1);
        for (int i = 0; i < 20 && o_door_open; i++) tick();
        call = 3'b100; tick(); call = '0;
        for (int i = 0; i < 40 && o_cur_floor != 2; i++) tick();
        check_eq("s2_pass_floor2_motor", o_motor, 1);
        call = 3'b001; tick(); call = '0;
        for (int i = 0; i < 40 && !o_door_open; i++) tick();
        check_eq("s2_continued_up", o_cur_floor, 3);
        for (int i = 0; i < 20 && o_motor != 2; i++) tick();
        check_eq("s2_reverse", o_motor, 2);
        for (int i = 0; i < 40 && !o_door_open; i++) tick();
        check_eq("s2_stop_floor1", o_cur_floor, 1);
        for (int i = 0; i < 20 && o_door_open; i++) tick();

        sp = 1'b1; call = 3'b010; tick(); call = '0;
        check_eq("s3_overload", {o_overload_flag, o_door_open, o_motor}, 4'b1100);
        check_eq("s3_pending", o_pending, 3'b010);
        tick(); tick();
        sp = 1'b0;
        for (int i = 0; i < 20 && o_motor != 1; i++) tick();
        check_eq("s3_departs_up", o_motor, 1);

        sp_hold = 0;
        for (int i = 0; i < 2500; i++) begin
            call = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            if (sp_hold > 0) begin
                sp_hold--; sp = 1'b1;
            end else if ($urandom_range(0, 80) == 0) begin
                sp_hold = $urandom_range(1, 6); sp = 1'b1;
            end else begin
                sp = 1'b0;
            end
            tick();
        end
        call = '0; sp = 1'b0;

        do_reset();
        call = 3'b100; tick(); call = '0;
        for (int i = 0; i < 40 && !o_door_open; i++) tick();
        for (int i = 0; i < 20 && o_door_open; i++) tick();
        call = 3'b001; tick(); call = '0;
        tick(); tick();
        check_eq("s6_moving_down", o_motor, 2);
        rst = 1'b1;
        tick();
        check_eq("s6_rst_motor", o_motor, 0);
        check_eq("s6_rst_pending", o_pending, 0);
        check_eq("s6_rst_cur_floor", o_cur_floor, 1);
        rst = 1'b0; pos = 0; fc = car_fc();

        call = 3'b100; tick(); call = '0;
        tick(); tick();
        force_on = 1; fc_force = 3'b011; fc = car_fc();
        tick();
        force_on = 0; fc = car_fc();
        check_eq("s7_fault", {o_fault, o_motor}, 3'b100);
        call = 3'b111; tick(); tick(); tick(); call = '0;
        check_eq("s7_pending_frozen", o_pending, 3'b100);
        check_eq("s7_still_fault", o_fault, 1);

        do_reset();
        stuck = 1; fc = car_fc();
        call = 3'b010; tick(); call = '0;
        tick();
        check_eq("s8_moving", o_motor, 1);
`ifdef LIFT_TRAVEL_WATCHDOG_EN
        repeat (TIMEOUT - 1) tick();
        check_eq("s8_no_fault_yet", o_fault, 0);
        tick();
        check_eq("s8_wd_fault", {o_fault, o_motor}, 3'b100);
`else
        repeat (100) tick();
        check_eq("s8_still_moving", {o_fault, o_motor}, 3'b001);
`endif
        stuck = 0;
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lift_call_scheduler.md
Name: lift_call_scheduler

Overview:
- Collective (SCAN) call scheduler and motor sequencer for the 3-floor freight lift.
- Latches floor call buttons into sticky pending requests and tracks car position from the limit switches.
- Chooses the next target floor, drives the 2-bit motor command, times door dwell and blocks departure on overload.
- Sits between the button/sensor inputs and the motor driver. The 2-digit display mux consumes its `cur_floor`/`target_floor`/`overload_flag` outputs.

Parameters:
- `DWELL_CYCLES`, default 8000000: clk cycles the car stays at a served floor (2 s at 4 MHz); minimum 2.
- `TIMEOUT_CYCLES`, default 40000000: maximum clk cycles allowed in one `MOVE_*` leg before FAULT (only with the watchdog macro).

Ports:
- `clk` in 1: system clock, 4 MHz.
- `reset` in 1: synchronous, active-high reset.
- `call` in 3: floor call buttons, bit0 = floor 1, already debounced, level.
- `fc` in 3: limit switches, bit0 = floor 1, high while the car is at that floor.
- `sp` in 1: overload sensor, high = overweight.
- `motor` out 2: 00 stop, 01 up, 10 down; 11 is never driven.
- `pending` out 3: registered sticky request lamps.
- `cur_floor` out 2: last floor reached, 1..3.
- `target_floor` out 2: floor being travelled to, 0 when not moving.
- `door_open` out 1: high in DWELL.
- `overload_flag` out 1: high in OVERLOAD.
- `fault` out 1: high in FAULT.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state IDLE, `motor`=00, `pending`=000, `cur_floor`=1, `target_floor`=0.
  - `door_open`=0, `overload_flag`=0, `fault`=0, direction register = UP, all counters 0.
  - Reset mid-travel stops the motor on that edge.
- Call latching: any `call[i]` sampled high sets `pending[i]` at that edge. Bits clear only on entry to DWELL at floor i+1.
  - If set and clear coincide on the same bit, clear wins; a still-held button re-sets it next edge.
  - `pending` keeps latching in OVERLOAD, but not in FAULT (frozen).
- States: IDLE, MOVE_UP, MOVE_DOWN, DWELL, OVERLOAD, FAULT. `motor`, `door_open`, `overload_flag` and `fault` are registered and change on the same edge as the state.
- IDLE, checked in priority order:
  - `sp`=1 -> OVERLOAD.
  - Pending at `cur_floor` -> DWELL.
  - Pending in the current direction -> MOVE in that direction.
  - Pending in the opposite direction -> MOVE opposite and flip direction.
  - Otherwise stay.
  - `target_floor` = nearest pending floor in the chosen direction.
- Latency: a button sampled at edge k gives `pending` at edge k; the MOVE state and `motor` follow at edge k+1.
- MOVE_UP / MOVE_DOWN:
  - On `fc` of the next floor in the travel direction going high, `cur_floor` updates.
  - If that floor is pending -> DWELL (motor 00, bit cleared); otherwise keep moving and recompute `target_floor`.
  - Floor 3 reached going up, or floor 1 going down, always -> DWELL.
  - `sp` is ignored while moving.
- DWELL:
  - `door_open`=1 and the counter counts `DWELL_CYCLES`, then -> IDLE.
  - A `call` at the current floor during DWELL restarts the counter and does not set `pending`.
  - `sp`=1 -> OVERLOAD.
- OVERLOAD:
  - `motor`=00, `door_open`=1, `overload_flag`=1.
  - When `sp`=0 -> DWELL with a fresh count.
- FAULT:
  - Entered from any state when more than one `fc` bit is high.
  - `motor`=00, `fault`=1, all other outputs hold.
  - Exit only by reset.
- `fc`=000 in IDLE/DWELL is tolerated (car between switches after reset); `cur_floor` still drives decisions.

Optional Feature:
- `LIFT_TRAVEL_WATCHDOG_EN` defined:
  - A 26-bit leg counter clears on MOVE entry and increments each MOVE cycle.
  - Reaching `TIMEOUT_CYCLES` -> FAULT.
- Undefined: no counter is compiled; MOVE legs are unbounded, and FAULT arises only from conflicting `fc`.

Decomposition:
- Package `lift_pkg` holds:
  - Motor codes `MOTOR_STOP`=00, `MOTOR_UP`=01, `MOTOR_DOWN`=10.
  - 3-bit state encoding.
  - Floor constants `FLOOR_1`..`FLOOR_3`.
  - A direction type.
- One sub-module, `lift_dwell_timer`: a load/restart/done down-counter sized by `$clog2(DWELL_CYCLES)`, reused for the watchdog when enabled.
- Scheduling decision stays in the top-level FSM.

Test Plan (`DWELL_CYCLES`=4, `TIMEOUT_CYCLES`=20):
- Reset, `fc`=001, `call`=100 for 1 cycle -> `pending`=100, next edge `motor`=01, `target_floor`=3. Pass `fc` 010 without stop; at `fc`=100: `motor`=00, `door_open`=1 for 4 cycles, `pending`=000, `cur_floor`=3.
- Car at floor 2 moving up to 3, then `call`=001 -> continue up; after dwell at 3, `motor`=10, stop at floor 1.
- Car idle at floor 1, `sp`=1 with `call`=010 -> `overload_flag`=1, `motor`=00, `pending`=010. Release `sp` -> 4-cycle dwell, then `motor`=01.
- `fc`=011 in MOVE_UP -> next edge `fault`=1, `motor`=00; `call` ignored until reset.
- Watchdog defined: MOVE_UP with `fc` stuck 000 for 20 cycles -> FAULT. Undefined: still MOVE_UP at cycle 100.
- Reset asserted mid-MOVE_DOWN -> `motor`=00, `pending`=000, `cur_floor`=1 on that same edge.
